// File: rtl/banked_ram.sv
// banked_ram: bank-interleaved single-port word memory with per-byte write
// enables, valid/ready request port, 1-cycle read response and a clearing
// init sweep after reset.
// Optional build macro: BANKED_RAM_PARITY_EN adds one even-parity bit per
// byte lane, an err_inj input and an rsp_perr output.
module banked_ram #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BANK_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
`ifdef BANKED_RAM_PARITY_EN
    input  logic                  err_inj,
    output logic                  rsp_perr,
`endif
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_done
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned NBANKS = 1 << BANK_BITS;
    localparam int unsigned ROW_W  = ADDR_W - BANK_BITS;
    localparam int unsigned ROWS   = 1 << ROW_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;

    logic                accept;
    logic                rd_fire;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [LANES-1:0]    wr_be;
    logic [NBANKS-1:0]   wr_bank_oh;
    logic [ROW_W-1:0]    wr_row;
    logic [BANK_BITS-1:0] rd_bank;
    logic [ROW_W-1:0]    rd_row;
    logic [7:0]          lane_rd [NBANKS][LANES];
    logic [DATA_W-1:0]   rd_word;

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

`ifdef BANKED_RAM_PARITY_EN
    logic                wr_inj;
    logic [LANES-1:0]    lane_perr [NBANKS];
    logic                rsp_perr_q;
`endif

    // Reset wins over a request presented on the same edge.
    assign accept    = (state_q == S_RUN) && req_valid && !rst;
    assign rd_fire   = accept && !req_we;
    assign req_ready = (state_q == S_RUN);
    assign init_done = (state_q == S_RUN);

    assign wr_row  = wr_addr[ROW_W-1:0];
    assign rd_bank = req_addr[ADDR_W-1 -: BANK_BITS];
    assign rd_row  = req_addr[ROW_W-1:0];

    // FSM state and sweep pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state and write-port steering: sweep in INIT, requests in RUN
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = req_addr;
        wr_data = req_wdata;
        wr_be   = req_be;
`ifdef BANKED_RAM_PARITY_EN
        wr_inj  = 1'b0;
`endif
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q[ADDR_W-1:0];
                wr_data = '0;
                wr_be   = '1;
                ptr_d   = ptr_q + PTR_ONE;
                // MSB of the incremented pointer marks the last word written
                if (ptr_d[ADDR_W]) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wr_en = accept && req_we;
`ifdef BANKED_RAM_PARITY_EN
                wr_inj = err_inj;
`endif
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // One-hot bank select for the write port
    always_comb begin
        wr_bank_oh = '0;
        if (wr_en) begin
            wr_bank_oh = {{(NBANKS-1){1'b0}}, 1'b1} << wr_addr[ADDR_W-1 -: BANK_BITS];
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] mem [ROWS];

            // Byte-lane storage; only the selected bank with its enable writes
            always_ff @(posedge clk) begin
                if (wr_bank_oh[b] && wr_be[l]) begin
                    mem[wr_row] <= wr_data[8*l +: 8];
                end
            end

            assign lane_rd[b][l] = mem[rd_row];

`ifdef BANKED_RAM_PARITY_EN
            logic par [ROWS];

            // Even parity per lane, optionally inverted for error injection
            always_ff @(posedge clk) begin
                if (wr_bank_oh[b] && wr_be[l]) begin
                    par[wr_row] <= (^wr_data[8*l +: 8]) ^ wr_inj;
                end
            end

            assign lane_perr[b][l] = (^mem[rd_row]) ^ par[rd_row];
`endif
        end
    end

    // Read mux across the addressed bank's lanes
    always_comb begin
        rd_word = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_word[8*l +: 8] = lane_rd[rd_bank][l];
        end
    end

    // Read response register; data holds while no response is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rd_fire;
            if (rd_fire) begin
                rsp_rdata_q <= rd_word;
            end
        end
    end

`ifdef BANKED_RAM_PARITY_EN
    // Parity error flag travels with the read response
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_perr_q <= 1'b0;
        end else if (rd_fire) begin
            rsp_perr_q <= |lane_perr[rd_bank];
        end
    end

    assign rsp_perr = rsp_perr_q;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: randomized and directed scoreboard bench for banked_ram.
// Honors BANKED_RAM_PARITY_EN when the same macro is given to the build.
module tb_banked_ram;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 12;
    localparam int unsigned BB    = 2;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
`ifdef BANKED_RAM_PARITY_EN
    logic          err_inj = 1'b0;
    logic          rsp_perr;
`endif

    banked_ram #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BANK_BITS (BB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
`ifdef BANKED_RAM_PARITY_EN
        .err_inj   (err_inj),
        .rsp_perr  (rsp_perr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        p;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [DEPTH];
    logic [1:0]  ref_bad [DEPTH];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic        rst_prev = 1'b0;
    logic [15:0] hold_exp = 16'h0;
    exp_t        e;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: each expected response must show up exactly on its due cycle
    always @(negedge clk) begin
        if (rst_prev) hold_exp = 16'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e.d});
`ifdef BANKED_RAM_PARITY_EN
            chk("rsp_perr", {31'b0, rsp_perr}, {31'b0, e.p});
`endif
            hold_exp = e.d;
        end else if (rsp_valid) begin
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
            chk("rdata_hold", {16'b0, rsp_rdata}, {16'b0, hold_exp});
        end
    end

    task automatic req(input logic we, input logic [11:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic inj);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
`ifdef BANKED_RAM_PARITY_EN
        err_inj   = inj;
`endif
        chk("req_ready", {31'b0, req_ready}, 32'd1);
        if (we) begin
            for (int l = 0; l < 2; l++) begin
                if (be[l]) begin
                    ref_mem[a][8*l +: 8] = d[8*l +: 8];
`ifdef BANKED_RAM_PARITY_EN
                    ref_bad[a][l] = inj;
`endif
                end
            end
        end else begin
            q.push_back('{ref_mem[a], |ref_bad[a], cyc + 1});
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Reset with a read held on the bus; ncyc < DEPTH aborts mid-sweep
    task automatic do_reset(input int unsigned ncyc);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = 16'h0;
            ref_bad[i] = 2'b0;
        end
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'b0, rsp_rdata}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
`ifdef BANKED_RAM_PARITY_EN
        chk("rst_rsp_perr", {31'b0, rsp_perr}, 32'd0);
`endif
        for (int unsigned i = 1; i < ncyc; i++) begin
            @(negedge clk);
            chk("init_req_ready", {31'b0, req_ready}, 32'd0);
            chk("init_init_done", {31'b0, init_done}, 32'd0);
        end
        if (ncyc == DEPTH) begin
            @(negedge clk);
            chk("sweep_req_ready", {31'b0, req_ready}, 32'd1);
            chk("sweep_init_done", {31'b0, init_done}, 32'd1);
            q.push_back('{16'h0, 1'b0, cyc + 1});
        end
    endtask

    logic [11:0] pool [8];
    logic [31:0] r;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        pool = '{12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'h405, 12'hC05, 12'h010, 12'h3A7};

        do_reset(DEPTH);

        req(1'b1, 12'h000, 16'h1234, 2'b11, 1'b0);
        req(1'b1, 12'hC05, 16'hBEEF, 2'b11, 1'b0);
        req(1'b0, 12'h000, 16'h0, 2'b00, 1'b0);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);
        req(1'b0, 12'h405, 16'h0, 2'b00, 1'b0);
        idle(1);

        req(1'b1, 12'hC05, 16'h0055, 2'b01, 1'b0);
        req(1'b1, 12'hC05, 16'hFFFF, 2'b00, 1'b0);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);

        req(1'b1, 12'h7FF, 16'hA5A5, 2'b11, 1'b0);
        req(1'b0, 12'h7FF, 16'h0, 2'b00, 1'b0);
        req(1'b0, 12'h000, 16'h0, 2'b00, 1'b0);
        req(1'b0, 12'h7FF, 16'h0, 2'b00, 1'b0);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);
        idle(2);

        do_reset(100);
        do_reset(DEPTH);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);
        req(1'b1, 12'hC05, 16'h7777, 2'b11, 1'b0);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);
        do_reset(DEPTH);
        req(1'b0, 12'hC05, 16'h0, 2'b00, 1'b0);
        idle(1);

`ifdef BANKED_RAM_PARITY_EN
        req(1'b1, 12'h010, 16'h00FF, 2'b11, 1'b1);
        req(1'b0, 12'h010, 16'h0, 2'b00, 1'b0);
        req(1'b1, 12'h010, 16'h00FF, 2'b11, 1'b0);
        req(1'b0, 12'h010, 16'h0, 2'b00, 1'b0);
        idle(1);
`endif

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (r[1:0] == 2'b00) begin
                idle(1);
            end else begin
                req(r[2], pool[r[10:8]], r[31:16], r[4:3], (r[6:5] == 2'b00));
            end
        end
        idle(3);

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
Parametrised, synchronous, bank-interleaved single-port word memory with per-byte write enables.
- Storage is split into 2^BANK_BITS banks selected by the upper address bits, each bank built from DATA_W/8 byte lanes.
- Replaces the fixed 4K x 16 bidirectional-bus array with a valid/ready request port, a separate 1-cycle-latency read response and a self-clearing init sweep after reset.
- Sits between a bus master (CPU/DMA) and on-chip storage.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8, min 8.
ADDR_W, 12, word address width; depth = 2^ADDR_W.
BANK_BITS, 2, bank select bits, taken from req_addr MSBs; 1 <= BANK_BITS < ADDR_W.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted when req_valid && req_ready.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  word address.
req_wdata  input  DATA_W  write data.
req_be  input  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i].
rsp_valid  output  1  read data valid, single-cycle pulse per read.
rsp_rdata  output  DATA_W  read data.
init_done  output  1  high once the init sweep has finished.

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0. The FSM enters INIT with the sweep pointer at 0.
- Address split:
  - bank = req_addr[ADDR_W-1 -: BANK_BITS]
  - row = req_addr[ADDR_W-BANK_BITS-1:0]
  - Bank select is one-hot internally. Only the selected bank's lanes see a write enable.
- FSM states:
  - INIT: writes 0 to one word per cycle, pointer 0 .. 2^ADDR_W-1, all lanes. req_ready=0. On the cycle after the last word is written, go to RUN and set init_done=1. The sweep takes exactly 2^ADDR_W cycles after rst deasserts.
  - RUN: req_ready=1 every cycle, no back-pressure. Stays in RUN until rst.
- Write (accepted, req_we=1): on that edge, each lane i with req_be[i]=1 stores its byte; lanes with be=0 keep their contents. be=0 is a legal no-op. A write produces no response.
- Read (accepted, req_we=0):
  - rsp_valid=1 on the next cycle, with rsp_rdata = word at req_addr. Latency is exactly 1.
  - Reads may be issued every cycle, to any mix of banks. Responses come back in order, one per cycle.
- Write followed by a read of the same address on the next cycle returns the newly written data.
- rsp_rdata holds its last value while rsp_valid=0.
- Requests with req_valid=1 while req_ready=0 (INIT) are ignored and not queued.
- Reset mid-operation (any state, including mid-INIT or a pending response):
  - the next cycle shows reset values;
  - the in-flight rsp_valid is dropped;
  - the sweep restarts at 0, so all contents are cleared again.
- Pointer wrap: the sweep pointer is ADDR_W+1 bits wide. Termination is detected on its MSB, so no aliasing occurs at 2^ADDR_W-1.

Optional Feature:
Macro: BANKED_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, computed on write; INIT writes parity 0.
  - Extra ports are added:
    - input err_inj (1): when high on an accepted write, the stored parity of every enabled lane is inverted.
    - output rsp_perr (1): valid with rsp_valid; 1 if any lane's stored parity mismatches its data. Reset value 0.
  - Data is returned unchanged; there is no correction.
- Undefined: no parity storage, no err_inj or rsp_perr ports, identical timing.

Test Plan:
- Release rst, hold req_valid=1 read 0x000 -> req_ready=0 and init_done=0 for 4096 cycles, then both =1. First accepted read returns 0x0000 with rsp_valid one cycle later.
- Write 0x1234 @0x000 be=11, write 0xBEEF @0xC05 be=11, read both -> 0x1234 then 0xBEEF on consecutive cycles; 0x405 (same row, bank1) reads 0x0000.
- Write 0x0055 @0xC05 be=01, then be=00 with 0xFFFF, read -> 0xBE55.
- Write 0xA5A5 @0x7FF, read 0x7FF the next cycle -> 0xA5A5. Back-to-back reads of 0x000, 0x7FF, 0xC05 -> three consecutive rsp_valid pulses, in order.
- Assert rst mid-INIT (cycle 100) and again one cycle after a read request -> rsp_valid=0 the next cycle, a full 4096-cycle sweep restarts, and 0xC05 reads 0x0000 afterwards.
- PARITY_EN: write 0x00FF @0x010 with err_inj=1, read -> rsp_rdata=0x00FF, rsp_perr=1. Rewrite with err_inj=0, read -> rsp_perr=0.
